// File: rtl/mph_pkg.sv
// mph_pkg: shared state encoding, register map and window decode for the project mux harness
package mph_pkg;
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_RST   = 2'd2;
  localparam logic [7:0] OFF_ACTIVE = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [31:0] DEAD_DATA = 32'hDEAD_DEAD;
  typedef struct packed {
    logic       harness;
    logic       proj;
    logic [4:0] idx;
    logic [7:0] off;
  } win_t;
  // Window 0 is the harness itself; window p+1 belongs to project p.
  function automatic win_t win_decode(input logic [31:0] adr, input logic [31:0] base, input int num_proj);
    logic [31:0] rel;
    win_t w;
    rel = adr - base;
    w.off = rel[7:0];
    w.harness = rel[31:8] == '0;
    w.proj = rel[31:8] != '0 && rel[31:8] <= 24'(num_proj);
    w.idx = 5'(rel[31:8] - 24'd1);
    return w;
  endfunction
endpackage

// File: rtl/mph_switch_fsm.sv
// mph_switch_fsm: drain/reset sequencing for a project switch
module mph_switch_fsm #(
  parameter int DRAIN_CYCLES = 4,
  parameter int RST_CYCLES   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_park,
  output logic [1:0] o_state,
  output logic       o_busy
);
  import mph_pkg::*;
  localparam int CW = $clog2((DRAIN_CYCLES > RST_CYCLES ? DRAIN_CYCLES : RST_CYCLES) + 1);
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  // DRAIN counts up from zero, RST counts down to one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RST;
      r_cnt   <= CW'(RST_CYCLES);
    end else if (i_start) begin
      r_state <= i_park ? ST_RUN : ST_DRAIN;
      r_cnt   <= '0;
    end else if (r_state == ST_DRAIN) begin
      if (r_cnt == CW'(DRAIN_CYCLES - 1)) begin
        r_state <= ST_RST;
        r_cnt   <= CW'(RST_CYCLES);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (r_state == ST_RST) begin
      if (r_cnt == CW'(1)) r_state <= ST_RUN;
      r_cnt <= r_cnt - 1'b1;
    end
  end
  assign o_state = r_state;
  assign o_busy  = r_state != ST_RUN;
endmodule

// File: rtl/project_mux_harness.sv
// project_mux_harness: muxes one of NUM_PROJ projects onto the pads and forwards its wishbone window
module project_mux_harness #(
  parameter int          NUM_PROJ     = 8,
  parameter int          IO_PADS      = 38,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          RST_CYCLES   = 8,
  parameter int          WB_TIMEOUT   = 255
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [31:0]                  wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [IO_PADS-1:0]           io_in,
  output logic [IO_PADS-1:0]           io_out,
  output logic [IO_PADS-1:0]           io_oeb,
  output logic [NUM_PROJ*IO_PADS-1:0]  proj_io_in,
  input  logic [NUM_PROJ*IO_PADS-1:0]  proj_io_out,
  input  logic [NUM_PROJ*IO_PADS-1:0]  proj_io_oeb,
  output logic [NUM_PROJ-1:0]          proj_rst_n,
  output logic [NUM_PROJ-1:0]          proj_stb,
  input  logic [NUM_PROJ-1:0]          proj_ack,
  input  logic [NUM_PROJ*32-1:0]       proj_dat
);
  import mph_pkg::*;
  localparam int TW = $clog2(WB_TIMEOUT + 1);
  win_t          w_win;
  logic [1:0]    w_state;
  logic          w_busy, w_req, w_run_ok, w_fwd_ok, w_fwd, w_pack, w_tmo, w_dead;
  logic          w_h_acc, w_act_wr, w_ctrl_wr, w_start, w_park, w_unused;
  logic [7:0]    w_active_nxt;
  logic [31:0]   w_pdat, w_hrd;
  logic [7:0]    r_active;
  logic          r_ack, r_sticky;
  logic [31:0]   r_dat;
  logic [TW-1:0] r_to;

  assign w_win        = win_decode(wbs_adr_i, BASE_ADDR, NUM_PROJ);
  assign w_req        = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_run_ok     = w_state == ST_RUN && r_active < 8'(NUM_PROJ);
  assign w_fwd_ok     = w_win.proj && {3'b0, w_win.idx} == r_active && w_state == ST_RUN;
  assign w_fwd        = w_req & w_fwd_ok;
  assign w_dead       = w_req & w_win.proj & ~w_fwd_ok;
  assign w_h_acc      = w_req & w_win.harness;
  assign w_act_wr     = w_h_acc & wbs_we_i & wbs_sel_i[0] & (w_win.off == OFF_ACTIVE);
  assign w_ctrl_wr    = w_h_acc & wbs_we_i & (w_win.off == OFF_CTRL);
  assign w_start      = w_act_wr | (w_ctrl_wr & wbs_dat_i[0]);
  assign w_active_nxt = w_act_wr ? wbs_dat_i[7:0] : r_active;
  // An out-of-range target has nothing to connect, so it skips the sequence.
  assign w_park       = w_active_nxt >= 8'(NUM_PROJ);
  assign w_tmo        = w_fwd & ~w_pack & (r_to == TW'(WB_TIMEOUT - 1));
  assign w_hrd        = wbs_we_i ? '0 :
                        w_win.off == OFF_ACTIVE ? {24'b0, r_active} :
                        w_win.off == OFF_STATUS ? {30'b0, r_sticky, w_busy} : '0;
  assign w_unused     = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};
  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;

  mph_switch_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .RST_CYCLES  (RST_CYCLES)
  ) u_fsm (
    .i_clk  (wb_clk_i),
    .i_rst_n(wb_rst_ni),
    .i_start(w_start),
    .i_park (w_park),
    .o_state(w_state),
    .o_busy (w_busy)
  );

  always_comb begin
    io_out     = '0;
    io_oeb     = '1;
    proj_io_in = '0;
    proj_rst_n = '0;
    proj_stb   = '0;
    w_pack     = 1'b0;
    w_pdat     = '0;
    for (int p = 0; p < NUM_PROJ; p++) begin
      if (w_run_ok && r_active == 8'(p)) begin
        io_out                            = proj_io_out[p*IO_PADS +: IO_PADS];
        io_oeb                            = proj_io_oeb[p*IO_PADS +: IO_PADS];
        proj_io_in[p*IO_PADS +: IO_PADS]  = io_in;
        proj_rst_n[p]                     = 1'b1;
      end
      if (w_fwd && w_win.idx == 5'(p)) begin
        proj_stb[p] = 1'b1;
        w_pack      = proj_ack[p];
        w_pdat      = proj_dat[p*32 +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_active <= '0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_sticky <= 1'b0;
      r_to     <= '0;
    end else begin
      r_ack    <= w_h_acc | w_dead | w_tmo | (w_fwd & w_pack);
      r_dat    <= w_h_acc ? w_hrd : (w_dead | w_tmo) ? DEAD_DATA : (w_fwd & w_pack) ? w_pdat : '0;
      r_to     <= (w_fwd & ~w_pack & ~w_tmo) ? r_to + 1'b1 : '0;
      r_active <= w_active_nxt;
      r_sticky <= w_tmo | (r_sticky & ~(w_ctrl_wr & wbs_dat_i[1]));
    end
  end
endmodule

// File: tb/tb_project_mux_harness.sv
// tb_project_mux_harness: directed + randomized check of the harness against a timeline model
module tb_project_mux_harness;
  localparam int NP = 4, IO = 38, DRN = 4, RSTC = 8, TMO = 255;
  localparam logic [31:0] BASE = 32'h3000_0000, DEAD = 32'hDEAD_DEAD;
  logic clk = 0, rst_n = 1, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, wdat = 0, rdat;
  logic ack;
  logic [IO-1:0] io_in = 0, io_out, io_oeb;
  logic [NP*IO-1:0] p_in, p_out = 0, p_oeb = 0;
  logic [NP-1:0] p_rst_n, p_stb, p_ack = 0;
  logic [NP*32-1:0] p_dat = 0;
  int n_chk = 0, n_fail = 0;
  int m_active = 0, m_t = 0, pend_act = 0;
  bit m_from_reset = 1, m_sticky = 0, pend = 0;

  always #5 clk = ~clk;

  project_mux_harness #(.NUM_PROJ(NP), .IO_PADS(IO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .proj_io_in(p_in), .proj_io_out(p_out),
    .proj_io_oeb(p_oeb), .proj_rst_n(p_rst_n), .proj_stb(p_stb), .proj_ack(p_ack), .proj_dat(p_dat)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Phase as a function of edges since the last reset release or switch command: 0 run, 1 drain, 2 reset.
  function automatic int exp_state();
    if (m_from_reset) return m_t < RSTC ? 2 : 0;
    if (m_active >= NP) return 0;
    return m_t < DRN ? 1 : m_t < DRN + RSTC ? 2 : 0;
  endfunction

  task automatic check_pads(input string tag);
    logic [IO-1:0] eo, eoe;
    logic [NP*IO-1:0] ein;
    logic [NP-1:0] er;
    eo = '0; eoe = '1; ein = '0; er = '0;
    if (exp_state() == 0 && m_active < NP) begin
      eo = p_out[m_active*IO +: IO];
      eoe = p_oeb[m_active*IO +: IO];
      ein[m_active*IO +: IO] = io_in;
      er[m_active] = 1'b1;
    end
    chk({tag, ".io_out"}, 160'(io_out), 160'(eo));
    chk({tag, ".io_oeb"}, 160'(io_oeb), 160'(eoe));
    chk({tag, ".proj_io_in"}, 160'(p_in), 160'(ein));
    chk({tag, ".proj_rst_n"}, 160'(p_rst_n), 160'(er));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_t = 0;
    else if (pend) begin pend = 0; m_t = 0; m_from_reset = 0; m_active = pend_act; end
    else m_t++;
    for (int i = 0; i < IO; i++) io_in[i] = 1'($urandom());
    for (int i = 0; i < NP*IO; i++) begin p_out[i] = 1'($urandom()); p_oeb[i] = 1'($urandom()); end
    #1;
    check_pads("pad");
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 0; m_t = 0; m_from_reset = 1; m_active = 0; m_sticky = 0; pend = 0;
    #1;
    check_pads("rst");
    chk("rst.ack", 160'(ack), 160'(1'b0));
    chk("rst.dat", 160'(rdat), 160'(32'h0));
  endtask

  task automatic wb_h(input logic [7:0] off, input logic w, input logic [31:0] d, input string tag);
    logic [31:0] er;
    er = off == 8'h00 ? 32'(m_active) : off == 8'h04 ? {30'b0, m_sticky, exp_state() != 0} : 32'h0;
    adr = BASE + 32'(off); we = w; wdat = d; sel = 4'hF; cyc = 1; stb = 1;
    if (w && off == 8'h00) begin pend = 1; pend_act = int'(d[7:0]); end
    if (w && off == 8'h08 && d[0]) begin pend = 1; pend_act = m_active; end
    tick();
    if (w && off == 8'h08 && d[1]) m_sticky = 0;
    chk({tag, ".ack"}, 160'(ack), 160'(1'b1));
    if (!w) chk({tag, ".dat"}, 160'(rdat), 160'(er));
    cyc = 0; stb = 0; we = 0;
    tick();
    chk({tag, ".ack_pulse"}, 160'(ack), 160'(1'b0));
  endtask

  task automatic wb_fwd(input int p, input logic w, input int dly, input logic [31:0] pd, input string tag);
    int ec;
    logic [31:0] ed;
    logic [NP-1:0] es;
    es = '0; es[p] = 1'b1;
    ec = dly < TMO ? dly + 1 : TMO;
    ed = dly < TMO ? pd : DEAD;
    adr = BASE + 32'((p + 1) * 256) + 32'($urandom_range(0, 63) * 4);
    we = w; wdat = $urandom(); sel = 4'hF; cyc = 1; stb = 1;
    for (int c = 0; c < ec; c++) begin
      if (c == dly) begin p_ack[p] = 1'b1; p_dat[p*32 +: 32] = pd; end
      #1;
      chk({tag, ".stb"}, 160'(p_stb), 160'(es));
      tick();
      p_ack = '0;
      if (c + 1 < ec) chk({tag, ".early_ack"}, 160'(ack), 160'(1'b0));
    end
    chk({tag, ".ack"}, 160'(ack), 160'(1'b1));
    chk({tag, ".dat"}, 160'(rdat), 160'(ed));
    if (dly >= TMO) m_sticky = 1;
    cyc = 0; stb = 0; we = 0;
    #1;
    chk({tag, ".stb_off"}, 160'(p_stb), 160'(0));
    tick();
    chk({tag, ".ack_pulse"}, 160'(ack), 160'(1'b0));
  endtask

  task automatic wb_dead(input int p, input string tag);
    adr = BASE + 32'((p + 1) * 256) + 32'h10; we = 0; sel = 4'hF; cyc = 1; stb = 1;
    #1;
    chk({tag, ".stb"}, 160'(p_stb), 160'(0));
    tick();
    chk({tag, ".ack"}, 160'(ack), 160'(1'b1));
    chk({tag, ".dat"}, 160'(rdat), 160'(DEAD));
    cyc = 0; stb = 0;
    tick();
    chk({tag, ".ack_pulse"}, 160'(ack), 160'(1'b0));
  endtask

  task automatic wb_drop(input int p, input int n, input string tag);
    adr = BASE + 32'((p + 1) * 256); we = 0; sel = 4'hF; cyc = 1; stb = 1;
    ticks(n);
    chk({tag, ".no_ack"}, 160'(ack), 160'(1'b0));
    cyc = 0; stb = 0;
    #1;
    chk({tag, ".stb_off"}, 160'(p_stb), 160'(0));
    tick();
  endtask

  initial begin
    for (int i = 0; i < NP*32; i++) p_dat[i] = 1'($urandom());
    #2;
    do_reset();
    ticks(2);
    rst_n = 1;
    ticks(14);
    wb_h(8'h00, 1, 32'd2, "wr_active2");
    wb_h(8'h04, 0, 0, "status_busy");
    wb_dead(2, "busy_win");
    ticks(12);
    wb_fwd(2, 0, 3, 32'h1234_5678, "fwd3");
    for (int k = 0; k < 6; k++) wb_fwd(2, 1'($urandom()), $urandom_range(0, 12), $urandom(), "fwd_rand");
    wb_dead(0, "inactive_win0");
    wb_dead(3, "inactive_win3");
    adr = BASE + 32'h500; we = 0; cyc = 1; stb = 1;
    for (int k = 0; k < 4; k++) begin tick(); chk("outside.no_ack", 160'(ack), 160'(1'b0)); end
    cyc = 0; stb = 0;
    tick();
    wb_h(8'h00, 0, 0, "rd_active2");
    wb_fwd(2, 0, 1000, 32'h0, "timeout");
    wb_h(8'h04, 0, 0, "status_sticky");
    wb_h(8'h08, 1, 32'h2, "ctrl_clr");
    wb_h(8'h04, 0, 0, "status_clr");
    wb_drop(2, 200, "drop");
    wb_fwd(2, 0, 1000, 32'h0, "timeout_after_drop");
    wb_h(8'h08, 1, 32'h2, "ctrl_clr2");
    wb_h(8'h08, 1, 32'h1, "ctrl_rerun");
    wb_h(8'h00, 1, 32'd1, "wr_active1_mid_drain");
    ticks(3);
    wb_h(8'h00, 1, 32'd9, "wr_active9");
    wb_h(8'h04, 0, 0, "status_parked");
    wb_h(8'h00, 0, 0, "rd_active9");
    wb_dead(1, "parked_win");
    wb_h(8'h08, 1, 32'h1, "ctrl_rerun_parked");
    ticks(4);
    wb_h(8'h00, 1, 32'd3, "wr_active3");
    ticks(6);
    do_reset();
    ticks(2);
    rst_n = 1;
    ticks(14);
    wb_h(8'h00, 0, 0, "rd_active_after_rst");
    wb_fwd(0, 0, 2, $urandom(), "fwd_p0");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
